// File: rtl/shift_pipe_ctrl_pkg.sv
// Shared types and width helpers for the shift_pipe_ctrl delay-line controller.
// Each stage carries valid/last sideband next to its payload.
package shift_pipe_ctrl_pkg;

   typedef struct packed {
      logic vld;
      logic lst;
   } sr_ctrl_t;

   localparam sr_ctrl_t SR_CTRL_IDLE = '{vld: 1'b0, lst: 1'b0};

   // Bits needed to count 0..depth inclusive; never less than one bit.
   function automatic int occ_width(input int depth);
      int w;
      w = $clog2(depth + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/shift_pipe_ctrl_shift_register.sv
// Enable-gated DEPTH-stage shift register; the low RESETW bits of every stage
// take the asynchronous reset, the remaining bits are reset-free.
module shift_register #(
   parameter int DATAW  = 8,
   parameter int RESETW = 0,
   parameter int DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DATAW-1:0] din,
   output logic [DATAW-1:0] dout
);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [DATAW-1:0] d;
         logic [DATAW-1:0] q;

         if (gi == 0) begin : g_head
            assign d = din;
         end else begin : g_body
            assign d = g_stage[gi-1].q;
         end

         if (RESETW > 0) begin : g_rst
            logic [RESETW-1:0] lo_reg;
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  lo_reg <= '0;
               end else if (en) begin
                  lo_reg <= d[RESETW-1:0];
               end
            end
            assign q[RESETW-1:0] = lo_reg;
         end

         if (RESETW < DATAW) begin : g_norst
            logic [DATAW-1:RESETW] hi_reg;
            always_ff @(posedge clk) begin
               if (en) begin
                  hi_reg <= d[DATAW-1:RESETW];
               end
            end
            assign q[DATAW-1:RESETW] = hi_reg;
         end
      end

      if (RESETW == 0) begin : g_no_reset
         logic unused_rst;
         assign unused_rst = rst;
      end
   endgenerate

   assign dout = g_stage[DEPTH-1].q;

endmodule

// File: rtl/shift_pipe_ctrl.sv
// Valid/ready controller for a fixed-depth enable-gated delay line: one shared
// shift enable moves data and sideband together; a full, stalled tail holds everything.
module shift_pipe_ctrl
   import shift_pipe_ctrl_pkg::*;
#(
   parameter  int DATAW = 8,
   parameter  int DEPTH = 4,
   localparam int OCCW  = occ_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [DATAW-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [DATAW-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [OCCW-1:0]  occupancy,
   output logic             busy
);

   sr_ctrl_t [DEPTH-1:0] ctrl_reg;
   sr_ctrl_t             ctrl_in;
   logic [OCCW-1:0]      occ_reg;
   logic [OCCW-1:0]      occ_next;
   logic                 shift;
   logic                 push;
   logic                 pop;

   // Bubbles are kept in place; only a valid tail that is not being taken stalls.
   assign shift    = (~ctrl_reg[DEPTH-1].vld | out_ready) & ~flush;
   assign in_ready = shift & ~reset;
   assign push     = in_valid & shift;
   assign pop      = ctrl_reg[DEPTH-1].vld & shift;

   assign ctrl_in = '{vld: in_valid, lst: in_valid & in_last};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_reg <= {DEPTH{SR_CTRL_IDLE}};
      end else if (flush) begin
         ctrl_reg <= {DEPTH{SR_CTRL_IDLE}};
      end else if (shift) begin
         ctrl_reg[0] <= ctrl_in;
         for (int i = 1; i < DEPTH; i++) begin
            ctrl_reg[i] <= ctrl_reg[i-1];
         end
      end
   end

   assign occ_next = occ_reg + OCCW'(push) - OCCW'(pop);

   // A flush discards everything, including a beat handed off on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_reg <= '0;
      end else if (flush) begin
         occ_reg <= '0;
      end else begin
         occ_reg <= occ_next;
      end
   end

   shift_register #(
      .DATAW (DATAW),
      .RESETW(0),
      .DEPTH (DEPTH)
   ) u_data (
      .clk (clk),
      .rst (reset),
      .en  (shift),
      .din (in_data),
      .dout(out_data)
   );

   assign out_valid = ctrl_reg[DEPTH-1].vld;
   assign out_last  = ctrl_reg[DEPTH-1].lst;
   assign occupancy = occ_reg;
   assign busy      = (occ_reg != '0);

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Directed bench for shift_pipe_ctrl (DEPTH=4): inputs change and registered
// outputs are sampled on the falling clock edge.
module tb_shift_pipe_ctrl;

   localparam int DATAW = 8;
   localparam int DEPTH = 4;
   localparam int OCCW  = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic [DATAW-1:0] in_data;
   logic             in_last;
   logic             in_ready;
   logic             out_valid;
   logic [DATAW-1:0] out_data;
   logic             out_last;
   logic             out_ready;
   logic [OCCW-1:0]  occupancy;
   logic             busy;

   int total = 0;
   int bad   = 0;

   shift_pipe_ctrl #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_last (out_last),
      .out_ready(out_ready),
      .occupancy(occupancy),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic ordy);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;

      // 1: stream 0x01..0x08 with downstream always ready
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         chk("t1_occ", occupancy, (c <= 4) ? c : (c <= 8) ? 4 : 12 - c);
         chk("t1_out_valid", out_valid, (c >= 4 && c <= 11) ? 1 : 0);
         if (c >= 4 && c <= 11) chk("t1_out_data", out_data, c - 3);
         if (c < 8) drive(1'b1, 8'(c + 1), 1'b0, 1'b1);
         else       drive(1'b0, 8'h00, 1'b0, 1'b1);
         #1;
         chk("t1_in_ready", in_ready, 1);
      end
      $display("test1 stream: done");

      // 2: fill four beats with downstream stalled, then release
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1'b1, 8'(c + 1), 1'b0, 1'b0);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(1'b1, 8'hAA, 1'b0, 1'b0);
         #1;
         chk("t2_in_ready", in_ready, 0);
         chk("t2_out_valid", out_valid, 1);
         chk("t2_out_data", out_data, 8'h01);
         chk("t2_occ", occupancy, 4);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t2_rel_valid", out_valid, (c < 4) ? 1 : 0);
         if (c < 4) chk("t2_rel_data", out_data, c + 1);
         chk("t2_rel_occ", occupancy, 4 - c);
         drive(1'b0, 8'h00, 1'b0, 1'b1);
      end
      $display("test2 backpressure: done");

      // 3: alternate valid/bubble, bubbles preserved at the output
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c >= 4 && (c - 4) < 8 && ((c - 4) % 2) == 0) begin
            chk("t3_out_valid", out_valid, 1);
            chk("t3_out_data", out_data, 8'h10 + c - 4);
         end else begin
            chk("t3_out_valid", out_valid, 0);
         end
         chk("t3_out_last", out_last, 0);
         drive((c < 8) && (c % 2 == 0), 8'(8'h10 + c), 1'b0, 1'b1);
      end
      $display("test3 bubbles: done");

      // 4: last flag on third beat; busy drops after it pops
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c >= 4 && c <= 6) begin
            chk("t4_out_valid", out_valid, 1);
            chk("t4_out_data", out_data, 8'h21 + c - 4);
         end
         chk("t4_out_last", out_last, (c == 6) ? 1 : 0);
         chk("t4_busy", busy, (c >= 1 && c <= 6) ? 1 : 0);
         if (c < 3) drive(1'b1, 8'(8'h21 + c), c == 2, 1'b1);
         else       drive(1'b0, 8'h00, 1'b0, 1'b1);
      end
      $display("test4 last/busy: done");

      // 5: flush with three beats in flight and a new beat offered
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(1'b1, 8'(8'h31 + c), 1'b0, 1'b1);
      end
      @(negedge clk);
      chk("t5_pre_occ", occupancy, 3);
      flush = 1'b1;
      drive(1'b1, 8'h99, 1'b0, 1'b1);
      #1;
      chk("t5_in_ready", in_ready, 0);
      @(negedge clk);
      flush = 1'b0;
      chk("t5_occ", occupancy, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_busy", busy, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t5_drain_valid", out_valid, 0);
      end
      $display("test5 flush: done");

      // 6: asynchronous reset mid-stream
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(1'b1, 8'(8'h60 + c), 1'b0, 1'b1);
      end
      @(negedge clk);
      chk("t6_pre_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_occ", occupancy, 0);
      chk("t6_rst_in_ready", in_ready, 0);
      @(negedge clk);
      chk("t6_rst_hold_valid", out_valid, 0);
      reset = 1'b0;
      drive(1'b1, 8'h5A, 1'b0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         drive(1'b0, 8'h00, 1'b0, 1'b1);
         chk("t6_lat_valid", out_valid, (k == 4) ? 1 : 0);
         if (k == 4) chk("t6_lat_data", out_data, 8'h5A);
      end
      $display("test6 reset: done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
